// File: rtl/ysyx_25040101_mem_arbiter_if.sv
// Bundles the IFU, LSU and downstream memory handshakes of the memory arbiter.
// The arbiter uses the slave modport; the requester/bus side uses master.
interface ysyx_25040101_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              ifu_req_valid_i;
  logic              ifu_req_ready_o;
  logic [ADDR_W-1:0] ifu_addr_i;
  logic              ifu_rsp_valid_o;
  logic              ifu_rsp_ready_i;

  logic              lsu_req_valid_i;
  logic              lsu_req_ready_o;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic              lsu_wen_i;
  logic [DATA_W-1:0] lsu_wdata_i;
  logic [MASK_W-1:0] lsu_wmask_i;
  logic              lsu_rsp_valid_o;
  logic              lsu_rsp_ready_i;

  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;

  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_wen_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [MASK_W-1:0] mem_wmask_o;
  logic              mem_rsp_valid_i;
  logic              mem_rsp_ready_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_err_i;

  modport slave (
    input  ifu_req_valid_i, ifu_addr_i, ifu_rsp_ready_i,
    input  lsu_req_valid_i, lsu_addr_i, lsu_wen_i, lsu_wdata_i, lsu_wmask_i, lsu_rsp_ready_i,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i, mem_err_i,
    output ifu_req_ready_o, ifu_rsp_valid_o,
    output lsu_req_ready_o, lsu_rsp_valid_o,
    output rsp_rdata_o, rsp_err_o,
    output mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o, mem_rsp_ready_o
  );

  modport master (
    output ifu_req_valid_i, ifu_addr_i, ifu_rsp_ready_i,
    output lsu_req_valid_i, lsu_addr_i, lsu_wen_i, lsu_wdata_i, lsu_wmask_i, lsu_rsp_ready_i,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i, mem_err_i,
    input  ifu_req_ready_o, ifu_rsp_valid_o,
    input  lsu_req_ready_o, lsu_rsp_valid_o,
    input  rsp_rdata_o, rsp_err_o,
    input  mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o, mem_rsp_ready_o
  );
endinterface

// File: rtl/ysyx_25040101_mem_arbiter.sv
// IFU/LSU arbiter for the single core memory port, one transaction at a time with bus timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed LSU priority.
//
// state     | meaning
// S_IDLE    | accepting a new request from the granted requester
// S_REQ     | presenting the registered request downstream
// S_RSP     | waiting for the downstream response
// S_DELIVER | holding the response for the owner until it is taken
module ysyx_25040101_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  ysyx_25040101_mem_arbiter_if.slave   bus
);
  localparam int MASK_W    = DATA_W / 8;
  localparam bit TO_EN     = (TIMEOUT_CYC > 0);
  localparam int CNT_W     = TO_EN ? $clog2(TIMEOUT_CYC + 2) : 1;
  localparam int TO_LAST_I = TO_EN ? TIMEOUT_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RSP     = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q;          // 0 = IFU, 1 = LSU
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic pick_lsu, pick_ifu, take, timeout_hit, owner_rsp_ready;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  // On a tie, favour whoever was not served last; LSU wins straight out of reset.
  assign pick_lsu = bus.lsu_req_valid_i & (~bus.ifu_req_valid_i | ~last_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= 1'b0;
    end else if (state_q == S_IDLE && take) begin
      last_q <= pick_lsu;
    end
  end
`else
  assign pick_lsu = bus.lsu_req_valid_i;
`endif

  assign pick_ifu = bus.ifu_req_valid_i & ~pick_lsu;
  assign take     = pick_lsu | pick_ifu;

  assign timeout_hit     = TO_EN && (cnt_q >= TO_LAST);
  assign owner_rsp_ready = owner_q ? bus.lsu_rsp_ready_i : bus.ifu_rsp_ready_i;

  // Ready is gated by reset so nothing looks accepted while the block is held in reset.
  assign bus.ifu_req_ready_o = (state_q == S_IDLE) & rst_n_i & pick_ifu;
  assign bus.lsu_req_ready_o = (state_q == S_IDLE) & rst_n_i & pick_lsu;
  assign bus.ifu_rsp_valid_o = (state_q == S_DELIVER) & ~owner_q;
  assign bus.lsu_rsp_valid_o = (state_q == S_DELIVER) &  owner_q;
  assign bus.rsp_rdata_o     = rdata_q;
  assign bus.rsp_err_o       = err_q;
  assign bus.mem_req_valid_o = (state_q == S_REQ);
  assign bus.mem_rsp_ready_o = (state_q == S_RSP);
  assign bus.mem_addr_o      = addr_q;
  assign bus.mem_wen_o       = wen_q;
  assign bus.mem_wdata_o     = wdata_q;
  assign bus.mem_wmask_o     = wmask_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.mem_req_ready_i)  state_d = S_RSP;
        else if (timeout_hit)     state_d = S_DELIVER;
      end
      S_RSP: begin
        if (bus.mem_rsp_valid_i || timeout_hit) state_d = S_DELIVER;
      end
      S_DELIVER: begin
        if (owner_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (take) begin
            owner_q <= pick_lsu;
            addr_q  <= pick_lsu ? bus.lsu_addr_i : bus.ifu_addr_i;
            wen_q   <= pick_lsu & bus.lsu_wen_i;
            wdata_q <= pick_lsu ? bus.lsu_wdata_i : '0;
            wmask_q <= pick_lsu ? bus.lsu_wmask_i : '0;
            cnt_q   <= '0;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (!bus.mem_req_ready_i && timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        S_RSP: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // A late response after an abort is never accepted since mem_rsp_ready_o drops with the state.
          if (bus.mem_rsp_valid_i) begin
            rdata_q <= bus.mem_rdata_i;
            err_q   <= bus.mem_err_i;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25040101_mem_arbiter.sv
// Directed + randomized bench for the memory arbiter against a transaction-level model.
module tb_ysyx_25040101_mem_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   last_lsu = 1'b0;

  always #5 clk = ~clk;

  ysyx_25040101_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_25040101_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: LSU wins ties unless round-robin says IFU is due.
  function automatic bit model_pick_lsu(input bit iv, input bit lv);
`ifdef ARB_ROUND_ROBIN_EN
    if (iv && lv) return !last_lsu;
`endif
    return lv;
  endfunction

  task automatic new_ifu();
    bus.ifu_req_valid_i = 1'b1;
    bus.ifu_addr_i      = $urandom;
  endtask

  task automatic new_lsu();
    bus.lsu_req_valid_i = 1'b1;
    bus.lsu_addr_i      = $urandom;
    bus.lsu_wen_i       = 1'($urandom_range(0, 1));
    bus.lsu_wdata_i     = $urandom;
    bus.lsu_wmask_i     = 4'($urandom_range(0, 15));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ifu_req_ready"}, bus.ifu_req_ready_o, 0);
    chk({tag, ".lsu_req_ready"}, bus.lsu_req_ready_o, 0);
    chk({tag, ".ifu_rsp_valid"}, bus.ifu_rsp_valid_o, 0);
    chk({tag, ".lsu_rsp_valid"}, bus.lsu_rsp_valid_o, 0);
    chk({tag, ".rsp_rdata"},     bus.rsp_rdata_o, 0);
    chk({tag, ".rsp_err"},       bus.rsp_err_o, 0);
    chk({tag, ".mem_req_valid"}, bus.mem_req_valid_o, 0);
    chk({tag, ".mem_rsp_ready"}, bus.mem_rsp_ready_o, 0);
    chk({tag, ".mem_addr"},      bus.mem_addr_o, 0);
    chk({tag, ".mem_wen"},       bus.mem_wen_o, 0);
    chk({tag, ".mem_wdata"},     bus.mem_wdata_o, 0);
    chk({tag, ".mem_wmask"},     bus.mem_wmask_o, 0);
  endtask

  // Full transaction from IDLE with at least one request raised at posedge+1.
  task automatic transact(input int req_wait, input int rsp_wait, input int hold, input bit refill,
                          input logic [31:0] rd, input bit er);
    bit          g;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_mask;
    bit          e_wen;
    #1;
    g = model_pick_lsu(bus.ifu_req_valid_i, bus.lsu_req_valid_i);
    chk("grant.ifu_ready", bus.ifu_req_ready_o, !g);
    chk("grant.lsu_ready", bus.lsu_req_ready_o, g);
    e_addr  = g ? bus.lsu_addr_i : bus.ifu_addr_i;
    e_wen   = g ? bus.lsu_wen_i : 1'b0;
    e_wdata = bus.lsu_wdata_i;
    e_mask  = g ? bus.lsu_wmask_i : 4'h0;
    tick();
    last_lsu = g;
    if (refill) begin
      if (g) new_lsu(); else new_ifu();
    end else begin
      if (g) bus.lsu_req_valid_i = 1'b0; else bus.ifu_req_valid_i = 1'b0;
    end
    for (int i = 0; i <= req_wait; i++) begin
      if (i == req_wait) bus.mem_req_ready_i = 1'b1;
      #1;
      chk("req.mem_req_valid", bus.mem_req_valid_o, 1);
      chk("req.mem_addr", bus.mem_addr_o, e_addr);
      chk("req.mem_wen", bus.mem_wen_o, e_wen);
      chk("req.mem_wmask", bus.mem_wmask_o, e_mask);
      if (g) chk("req.mem_wdata", bus.mem_wdata_o, e_wdata);
      chk("req.no_grant", {bus.ifu_req_ready_o, bus.lsu_req_ready_o}, 0);
      chk("req.no_rsp", {bus.ifu_rsp_valid_o, bus.lsu_rsp_valid_o}, 0);
      tick();
    end
    bus.mem_req_ready_i = 1'b0;
    for (int j = 0; j <= rsp_wait; j++) begin
      if (j == rsp_wait) begin
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rdata_i     = rd;
        bus.mem_err_i       = er;
      end
      #1;
      chk("rsp.mem_rsp_ready", bus.mem_rsp_ready_o, 1);
      chk("rsp.mem_req_valid", bus.mem_req_valid_o, 0);
      chk("rsp.no_rsp", {bus.ifu_rsp_valid_o, bus.lsu_rsp_valid_o}, 0);
      tick();
    end
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rdata_i     = $urandom;
    bus.mem_err_i       = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) begin
        if (g) bus.lsu_rsp_ready_i = 1'b1; else bus.ifu_rsp_ready_i = 1'b1;
      end
      #1;
      chk("dlv.ifu_rsp_valid", bus.ifu_rsp_valid_o, !g);
      chk("dlv.lsu_rsp_valid", bus.lsu_rsp_valid_o, g);
      chk("dlv.rdata", bus.rsp_rdata_o, rd);
      chk("dlv.err", bus.rsp_err_o, er);
      chk("dlv.no_grant", {bus.ifu_req_ready_o, bus.lsu_req_ready_o, bus.mem_req_valid_o}, 0);
      chk("dlv.mem_rsp_ready", bus.mem_rsp_ready_o, 0);
      tick();
    end
    bus.ifu_rsp_ready_i = 1'b0;
    bus.lsu_rsp_ready_i = 1'b0;
    bus.mem_err_i       = 1'b0;
  endtask

  // Transaction that never gets a response; req_wait >= TO means the request is never accepted.
  task automatic timeout_txn(input int req_wait);
    bit g;
    bit in_req;
    #1;
    g = model_pick_lsu(bus.ifu_req_valid_i, bus.lsu_req_valid_i);
    chk("to.ifu_ready", bus.ifu_req_ready_o, !g);
    chk("to.lsu_ready", bus.lsu_req_ready_o, g);
    tick();
    last_lsu = g;
    if (g) bus.lsu_req_valid_i = 1'b0; else bus.ifu_req_valid_i = 1'b0;
    in_req = 1'b1;
    for (int c = 0; c < TO; c++) begin
      if (in_req && c == req_wait) bus.mem_req_ready_i = 1'b1;
      #1;
      chk("to.mem_req_valid", bus.mem_req_valid_o, in_req);
      chk("to.mem_rsp_ready", bus.mem_rsp_ready_o, !in_req);
      chk("to.no_rsp", {bus.ifu_rsp_valid_o, bus.lsu_rsp_valid_o}, 0);
      tick();
      if (in_req && c == req_wait) begin
        in_req = 1'b0;
        bus.mem_req_ready_i = 1'b0;
      end
    end
    if (g) bus.lsu_rsp_ready_i = 1'b1; else bus.ifu_rsp_ready_i = 1'b1;
    #1;
    chk("to.ifu_rsp_valid", bus.ifu_rsp_valid_o, !g);
    chk("to.lsu_rsp_valid", bus.lsu_rsp_valid_o, g);
    chk("to.rdata", bus.rsp_rdata_o, 0);
    chk("to.err", bus.rsp_err_o, 1);
    chk("to.mem_idle", {bus.mem_req_valid_o, bus.mem_rsp_ready_o}, 0);
    tick();
    bus.ifu_rsp_ready_i = 1'b0;
    bus.lsu_rsp_ready_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ifu_req_valid_i = 1'b0;
    bus.ifu_addr_i      = '0;
    bus.ifu_rsp_ready_i = 1'b0;
    bus.lsu_req_valid_i = 1'b0;
    bus.lsu_addr_i      = '0;
    bus.lsu_wen_i       = 1'b0;
    bus.lsu_wdata_i     = '0;
    bus.lsu_wmask_i     = '0;
    bus.lsu_rsp_ready_i = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rdata_i     = '0;
    bus.mem_err_i       = 1'b0;

    // Reset state, with a request pending that must not be accepted.
    tick();
    bus.ifu_req_valid_i = 1'b1;
    #1;
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    bus.ifu_req_valid_i = 1'b0;
    tick();

    // IFU-only read with immediate memory.
    bus.ifu_req_valid_i = 1'b1;
    bus.ifu_addr_i      = 32'h8000_0000;
    transact(0, 0, 0, 1'b0, 32'h0010_0093, 1'b0);

    // Simultaneous IFU read and LSU store.
    new_ifu();
    bus.lsu_req_valid_i = 1'b1;
    bus.lsu_addr_i      = 32'h8000_1000;
    bus.lsu_wen_i       = 1'b1;
    bus.lsu_wdata_i     = 32'hDEAD_BEEF;
    bus.lsu_wmask_i     = 4'hF;
    transact(0, 0, 0, 1'b0, $urandom, 1'b0);
    transact(0, 0, 0, 1'b0, $urandom, 1'b0);

    // Both requesters kept busy back-to-back, then drained.
    new_ifu();
    new_lsu();
    for (int k = 0; k < 4; k++)
      transact($urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b1, $urandom, 1'($urandom_range(0, 1)));
    transact(0, 0, 0, 1'b0, $urandom, 1'b0);
    transact(0, 0, 0, 1'b0, $urandom, 1'b0);

    // Owner stalls the response for 5 cycles while the other requester waits.
    new_ifu();
    new_lsu();
    transact(1, 1, 5, 1'b0, $urandom, 1'b1);
    transact(0, 0, 0, 1'b0, $urandom, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 12; k++) begin
      if (!bus.ifu_req_valid_i && $urandom_range(0, 1) == 1) new_ifu();
      if (!bus.lsu_req_valid_i && $urandom_range(0, 1) == 1) new_lsu();
      if (!bus.ifu_req_valid_i && !bus.lsu_req_valid_i) new_lsu();
      transact($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0,
               $urandom, 1'($urandom_range(0, 3) == 0));
    end
    while (bus.ifu_req_valid_i || bus.lsu_req_valid_i)
      transact(0, 0, 0, 1'b0, $urandom, 1'b0);

    // Timeouts: response never arrives, then request never accepted.
    bus.ifu_req_valid_i = 1'b1;
    bus.ifu_addr_i      = 32'h8000_0040;
    timeout_txn(0);
    new_lsu();
    timeout_txn(100);

    // Asynchronous reset while waiting for the response.
    new_ifu();
    #1;
    chk("rst.ifu_ready", bus.ifu_req_ready_o, 1);
    tick();
    bus.ifu_req_valid_i = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    #1;
    chk("rst.in_rsp", bus.mem_rsp_ready_o, 1);
    #2;
    rst_n = 1'b0;
    new_ifu();
    #1;
    chk_all_zero("midrst");
    tick();
    rst_n = 1'b1;
    last_lsu = 1'b0;
    transact(0, 1, 0, 1'b0, $urandom, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
